// File: rtl/accel_pkg.sv
// Shared definitions for the AXI-Stream burst generator: FSM states,
// command-word field layout and data-mode codes.
package accel_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } burst_state_e;

    // Command word layout
    localparam int unsigned CMD_W         = 32;
    localparam int unsigned CMD_MODE_LSB  = 0;
    localparam int unsigned CMD_MODE_MSB  = 1;
    localparam int unsigned CMD_START_BIT = 2;
    localparam int unsigned CMD_ABORT_BIT = 3;
    localparam int unsigned CMD_LEN_LSB   = 8;
    localparam int unsigned CMD_LEN_MSB   = 23;
    localparam int unsigned CMD_CH_LSB    = 24;
    localparam int unsigned CMD_CH_MSB    = 27;

    localparam int unsigned MODE_W     = CMD_MODE_MSB - CMD_MODE_LSB + 1;
    localparam int unsigned LEN_W      = CMD_LEN_MSB - CMD_LEN_LSB + 1;
    localparam int unsigned CH_FIELD_W = CMD_CH_MSB - CMD_CH_LSB + 1;

    // Data modes: incrementing pattern and constant seed
    localparam logic [MODE_W-1:0] MODE_INC   = 2'd0;
    localparam logic [MODE_W-1:0] MODE_CONST = 2'd1;

    // Only the two defined modes are accepted; codes 2 and 3 are reserved.
    function automatic logic mode_supported(input logic [MODE_W-1:0] mode);
        return (mode == MODE_INC) || (mode == MODE_CONST);
    endfunction

endpackage

// File: rtl/axis_cmd_decode.sv
// Command front end: start-edge detection, command validation and
// per-burst precomputation (beat count, last-beat byte enables).
module axis_cmd_decode
    import accel_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned KEEP_W = DATA_W / 8,
    parameter int unsigned CH_N   = 4,
    parameter int unsigned CH_W   = 2
) (
    input  logic              sclk,
    input  logic              s_rst,
    input  logic              i_idle,
    input  logic [CMD_W-1:0]  i_cmd,
    input  logic [DATA_W-1:0] i_seed,
    output logic              o_go,
    output logic              o_err,
    output logic [MODE_W-1:0] o_mode,
    output logic [CH_W-1:0]   o_dest,
    output logic [DATA_W-1:0] o_seed,
    output logic [LEN_W-1:0]  o_beats,
    output logic [KEEP_W-1:0] o_last_keep
);

    logic                  r_start_prev;
    logic                  r_go;
    logic                  r_err;
    logic [MODE_W-1:0]     r_mode;
    logic [CH_W-1:0]       r_dest;
    logic [DATA_W-1:0]     r_seed;
    logic [LEN_W-1:0]      r_beats;
    logic [KEEP_W-1:0]     r_last_keep;

    logic                  w_start_edge;
    logic                  w_accept;
    logic                  w_valid;
    logic [MODE_W-1:0]     w_mode;
    logic [LEN_W-1:0]      w_len;
    logic [CH_FIELD_W-1:0] w_ch;
    logic [31:0]           w_rem;
    logic [LEN_W-1:0]      w_beats;
    logic [KEEP_W-1:0]     w_keep;
    logic                  w_unused_bits;

    assign w_mode  = i_cmd[CMD_MODE_MSB:CMD_MODE_LSB];
    assign w_len   = i_cmd[CMD_LEN_MSB:CMD_LEN_LSB];
    assign w_ch    = i_cmd[CMD_CH_MSB:CMD_CH_LSB];

    // Abort is consumed by the top-level FSM; the rest is reserved.
    assign w_unused_bits = ^{i_cmd[31:28], i_cmd[7:4], i_cmd[CMD_ABORT_BIT]};

    assign w_start_edge = i_cmd[CMD_START_BIT] & ~r_start_prev;
    assign w_valid      = (w_len != '0) && (32'(w_ch) < CH_N) && mode_supported(w_mode);
    assign w_accept     = w_start_edge & i_idle;

    // Beat count is ceil(length / KEEP_W); KEEP_W is a power of two.
    assign w_beats = LEN_W'((32'(w_len) + KEEP_W - 32'd1) / KEEP_W);
    assign w_rem   = 32'(w_len) % KEEP_W;

    // Last-beat byte enables: low remainder bytes, or full when length is a multiple.
    always_comb begin
        w_keep = '1;
        if (w_rem != 32'd0) begin
            for (int unsigned i = 0; i < KEEP_W; i++) begin
                w_keep[i] = (i < w_rem);
            end
        end
    end

    // Edge register, one-cycle go/err pulses and the latched command fields.
    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            r_start_prev <= 1'b0;
            r_go         <= 1'b0;
            r_err        <= 1'b0;
            r_mode       <= '0;
            r_dest       <= '0;
            r_seed       <= '0;
            r_beats      <= '0;
            r_last_keep  <= '0;
        end else begin
            r_start_prev <= i_cmd[CMD_START_BIT];
            r_go         <= w_accept & w_valid;
            r_err        <= w_accept & ~w_valid;
            if (w_accept && w_valid) begin
                r_mode      <= w_mode;
                r_dest      <= CH_W'(w_ch);
                r_seed      <= i_seed;
                r_beats     <= w_beats;
                r_last_keep <= w_keep;
            end
        end
    end

    assign o_go        = r_go;
    assign o_err       = r_err;
    assign o_mode      = r_mode;
    assign o_dest      = r_dest;
    assign o_seed      = r_seed;
    assign o_beats     = r_beats;
    assign o_last_keep = r_last_keep;

endmodule

// File: rtl/axis_burst_gen.sv
// AXI-Stream burst generator: accepts a command word, then emits a burst of
// incrementing or constant data beats with tlast/tkeep framing and abort.
module axis_burst_gen
    import accel_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned KEEP_W = DATA_W / 8,
    parameter int unsigned CH_N   = 4,
    localparam int unsigned CH_W  = (CH_N > 1) ? $clog2(CH_N) : 1
) (
    input  logic              sclk,
    input  logic              s_rst,
    input  logic [31:0]       cmd_reg,
    input  logic [DATA_W-1:0] cfg_seed,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic [KEEP_W-1:0] m_axis_tkeep,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic [CH_W-1:0]   m_axis_tdest,
    output logic              busy,
    output logic              task_finish,
    output logic              cmd_err
);

    localparam logic [STATE_W-1:0] S_IDLE = ST_IDLE;
    localparam logic [STATE_W-1:0] S_RUN  = ST_RUN;
    localparam logic [STATE_W-1:0] S_DONE = ST_DONE;
    localparam int unsigned        CNT_W  = LEN_W + 1;

    logic [STATE_W-1:0] r_state;
    logic               r_tvalid;
    logic               r_tlast;
    logic [DATA_W-1:0]  r_tdata;
    logic [KEEP_W-1:0]  r_tkeep;
    logic [CH_W-1:0]    r_tdest;
    logic               r_busy;
    logic               r_finish;
    logic [LEN_W-1:0]   r_beat;
    logic               r_abort;

    logic [STATE_W-1:0] w_state_nxt;
    logic               w_tvalid_nxt;
    logic               w_tlast_nxt;
    logic [DATA_W-1:0]  w_tdata_nxt;
    logic [KEEP_W-1:0]  w_tkeep_nxt;
    logic [CH_W-1:0]    w_tdest_nxt;
    logic               w_busy_nxt;
    logic               w_finish_nxt;
    logic [LEN_W-1:0]   w_beat_nxt;
    logic               w_abort_nxt;

    logic               w_go;
    logic               w_err;
    logic [MODE_W-1:0]  w_mode;
    logic [CH_W-1:0]    w_dest;
    logic [DATA_W-1:0]  w_seed;
    logic [LEN_W-1:0]   w_beats;
    logic [KEEP_W-1:0]  w_last_keep;

    logic               w_xfer;
    logic               w_abort_seen;
    logic               w_nat_last;

    axis_cmd_decode #(
        .DATA_W (DATA_W),
        .KEEP_W (KEEP_W),
        .CH_N   (CH_N),
        .CH_W   (CH_W)
    ) u_decode (
        .sclk        (sclk),
        .s_rst       (s_rst),
        .i_idle      (r_state == S_IDLE),
        .i_cmd       (cmd_reg),
        .i_seed      (cfg_seed),
        .o_go        (w_go),
        .o_err       (w_err),
        .o_mode      (w_mode),
        .o_dest      (w_dest),
        .o_seed      (w_seed),
        .o_beats     (w_beats),
        .o_last_keep (w_last_keep)
    );

    assign w_xfer       = r_tvalid & m_axis_tready;
    // An abort seen while a beat is stalled is remembered until that beat moves.
    assign w_abort_seen = r_abort | cmd_reg[CMD_ABORT_BIT];
    // The beat following the current one is the natural final beat.
    assign w_nat_last   = ({1'b0, r_beat} + CNT_W'(2)) == {1'b0, w_beats};

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt  = r_state;
        w_tvalid_nxt = r_tvalid;
        w_tlast_nxt  = r_tlast;
        w_tdata_nxt  = r_tdata;
        w_tkeep_nxt  = r_tkeep;
        w_tdest_nxt  = r_tdest;
        w_beat_nxt   = r_beat;
        w_abort_nxt  = r_abort;
        w_finish_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_go) begin
                    w_state_nxt  = S_RUN;
                    w_tvalid_nxt = 1'b1;
                    w_tdata_nxt  = w_seed;
                    w_tdest_nxt  = w_dest;
                    w_beat_nxt   = '0;
                    w_abort_nxt  = 1'b0;
                    w_tlast_nxt  = (w_beats == LEN_W'(1));
                    w_tkeep_nxt  = (w_beats == LEN_W'(1)) ? w_last_keep : '1;
                end
            end
            S_RUN: begin
                if (w_xfer) begin
                    w_abort_nxt = 1'b0;
                    if (r_tlast) begin
                        w_state_nxt  = S_DONE;
                        w_tvalid_nxt = 1'b0;
                        w_tlast_nxt  = 1'b0;
                        w_finish_nxt = 1'b1;
                    end else begin
                        w_beat_nxt  = r_beat + LEN_W'(1);
                        w_tdata_nxt = (w_mode == MODE_CONST) ? w_seed : r_tdata + DATA_W'(1);
                        w_tlast_nxt = w_abort_seen | w_nat_last;
                        w_tkeep_nxt = (w_nat_last && !w_abort_seen) ? w_last_keep : '1;
                    end
                end else begin
                    w_abort_nxt = w_abort_seen;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt  = S_IDLE;
                w_tvalid_nxt = 1'b0;
                w_tlast_nxt  = 1'b0;
            end
        endcase
        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            r_state  <= S_IDLE;
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            r_tdata  <= '0;
            r_tkeep  <= '0;
            r_tdest  <= '0;
            r_busy   <= 1'b0;
            r_finish <= 1'b0;
            r_beat   <= '0;
            r_abort  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_tvalid <= w_tvalid_nxt;
            r_tlast  <= w_tlast_nxt;
            r_tdata  <= w_tdata_nxt;
            r_tkeep  <= w_tkeep_nxt;
            r_tdest  <= w_tdest_nxt;
            r_busy   <= w_busy_nxt;
            r_finish <= w_finish_nxt;
            r_beat   <= w_beat_nxt;
            r_abort  <= w_abort_nxt;
        end
    end

    assign m_axis_tdata  = r_tdata;
    assign m_axis_tkeep  = r_tkeep;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tlast  = r_tlast;
    assign m_axis_tdest  = r_tdest;
    assign busy          = r_busy;
    assign task_finish   = r_finish;
    assign cmd_err       = w_err;

endmodule

// File: tb/tb_axis_burst_gen.sv
// Directed self-checking bench for axis_burst_gen (DATA_W=64, CH_N=4).
module tb_axis_burst_gen;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned KEEP_W = 8;
    localparam int unsigned CH_N   = 4;
    localparam int unsigned CH_W   = 2;

    logic              sclk = 1'b0;
    logic              s_rst;
    logic [31:0]       cmd_reg;
    logic [DATA_W-1:0] cfg_seed;
    logic [DATA_W-1:0] m_axis_tdata;
    logic [KEEP_W-1:0] m_axis_tkeep;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic              m_axis_tlast;
    logic [CH_W-1:0]   m_axis_tdest;
    logic              busy;
    logic              task_finish;
    logic              cmd_err;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] q_data[$];
    logic [KEEP_W-1:0] q_keep[$];
    logic              q_last[$];
    logic [CH_W-1:0]   q_dest[$];
    int                n_finish;
    int                n_err;
    int                n_unstable;
    int                first_valid;
    bit                timed_out;
    logic              rst_valid;

    always #5 sclk = ~sclk;

    axis_burst_gen #(.DATA_W(DATA_W), .KEEP_W(KEEP_W), .CH_N(CH_N)) dut (
        .sclk          (sclk),
        .s_rst         (s_rst),
        .cmd_reg       (cmd_reg),
        .cfg_seed      (cfg_seed),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tdest  (m_axis_tdest),
        .busy          (busy),
        .task_finish   (task_finish),
        .cmd_err       (cmd_err)
    );

    // Present the command with start low, then raise start one cycle later.
    task automatic issue(input logic [31:0] cmd, input logic [DATA_W-1:0] seed);
        @(negedge sclk);
        cmd_reg  = cmd & ~32'h4;
        cfg_seed = seed;
        @(negedge sclk);
        cmd_reg  = cmd | 32'h4;
    endtask

    // Act as the sink: record transferred beats and side events until the
    // burst finishes, a few cycles pass after tlast, or the cycle budget runs out.
    task automatic collect(input int max_cyc, input bit toggle_rdy, input int abort_beat,
                           input int restart_beat, input int rst_beat);
        int cyc = 0;
        int post = -1;
        bit stalled = 0;
        bit fin = 0;
        bit did_rst = 0;
        logic [DATA_W-1:0] sd = '0;
        logic [KEEP_W-1:0] sk = '0;
        logic              sl = 1'b0;
        q_data.delete(); q_keep.delete(); q_last.delete(); q_dest.delete();
        n_finish = 0; n_err = 0; n_unstable = 0; first_valid = -1;
        timed_out = 0; rst_valid = 1'b0;
        while (!fin) begin
            @(negedge sclk);
            cyc++;
            if (cyc == 1) cmd_reg[2] = 1'b0;
            if (!did_rst && rst_beat > 0 && q_data.size() == rst_beat) begin
                s_rst = 1'b1;
                #1;
                rst_valid = m_axis_tvalid;
                @(negedge sclk);
                s_rst   = 1'b0;
                did_rst = 1;
                post    = 0;
                stalled = 0;
            end
            if (task_finish) n_finish++;
            if (cmd_err) n_err++;
            if (m_axis_tvalid && first_valid < 0) first_valid = cyc;
            if (stalled && (!m_axis_tvalid || m_axis_tdata !== sd || m_axis_tkeep !== sk ||
                            m_axis_tlast !== sl))
                n_unstable++;
            m_axis_tready = toggle_rdy ? (cyc % 2 == 1) : 1'b1;
            stalled = 0;
            if (m_axis_tvalid && !did_rst) begin
                if (m_axis_tready) begin
                    q_data.push_back(m_axis_tdata);
                    q_keep.push_back(m_axis_tkeep);
                    q_last.push_back(m_axis_tlast);
                    q_dest.push_back(m_axis_tdest);
                    if (q_data.size() == abort_beat) cmd_reg[3] = 1'b1;
                    if (restart_beat > 0 && q_data.size() == restart_beat) cmd_reg[2] = 1'b1;
                    if (restart_beat > 0 && q_data.size() == restart_beat + 2) cmd_reg[2] = 1'b0;
                    if (m_axis_tlast && post < 0) post = 0;
                end else begin
                    stalled = 1;
                    sd = m_axis_tdata; sk = m_axis_tkeep; sl = m_axis_tlast;
                end
            end
            if (post >= 0) post++;
            if (n_finish > 0 || post > 4) fin = 1;
            if (cyc >= max_cyc) begin
                timed_out = 1;
                fin = 1;
            end
        end
    endtask

    task automatic test_reset();
        s_rst = 1'b1; cmd_reg = '0; cfg_seed = '0; m_axis_tready = 1'b0;
        repeat (3) @(negedge sclk);
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b want 0", m_axis_tvalid); end
        checks++; if ({m_axis_tlast, busy, task_finish, cmd_err} !== 4'b0) begin errors++;
            $display("FAIL reset_flags got %b want 0000", {m_axis_tlast, busy, task_finish, cmd_err}); end
        checks++; if (m_axis_tdata !== '0) begin errors++; $display("FAIL reset_tdata got %h want 0", m_axis_tdata); end
        checks++; if ({m_axis_tkeep, m_axis_tdest} !== '0) begin errors++;
            $display("FAIL reset_keep_dest got %h/%h want 0/0", m_axis_tkeep, m_axis_tdest); end
        @(negedge sclk);
        s_rst = 1'b0;
    endtask

    task automatic test_long_inc();
        int bad_d = 0, bad_k = 0, bad_l = 0, bad_t = 0;
        issue(32'h0066D780, 64'd0);
        collect(4000, 0, -1, -1, -1);
        for (int i = 0; i < q_data.size(); i++) begin
            if (q_data[i] !== 64'(i)) bad_d++;
            if (i < q_data.size() - 1 && q_keep[i] !== 8'hFF) bad_k++;
            if (q_last[i] !== (i == q_data.size() - 1)) bad_l++;
            if (q_dest[i] !== 2'd0) bad_t++;
        end
        checks++; if (timed_out) begin errors++; $display("FAIL long_timeout got 1 want 0"); end
        checks++; if (first_valid !== 2) begin errors++; $display("FAIL long_latency got %0d want 2", first_valid); end
        checks++; if (q_data.size() !== 3291) begin errors++; $display("FAIL long_beats got %0d want 3291", q_data.size()); end
        checks++; if (bad_d !== 0) begin errors++; $display("FAIL long_data got %0d bad beats want 0", bad_d); end
        checks++; if (bad_k !== 0) begin errors++; $display("FAIL long_keep got %0d bad beats want 0", bad_k); end
        checks++; if (q_keep[$] !== 8'h7F) begin errors++; $display("FAIL long_last_keep got %h want 7f", q_keep[$]); end
        checks++; if (bad_l !== 0) begin errors++; $display("FAIL long_tlast got %0d bad beats want 0", bad_l); end
        checks++; if (bad_t !== 0) begin errors++; $display("FAIL long_tdest got %0d bad beats want 0", bad_t); end
        checks++; if (n_finish !== 1) begin errors++; $display("FAIL long_finish got %0d want 1", n_finish); end
        @(negedge sclk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL long_busy_end got %b want 0", busy); end
    endtask

    task automatic test_const_stall();
        int bad_d = 0;
        issue(32'h02001001, 64'hA5A5A5A5A5A5A5A5);
        collect(100, 1, -1, -1, -1);
        for (int i = 0; i < q_data.size(); i++)
            if (q_data[i] !== 64'hA5A5A5A5A5A5A5A5 || q_keep[i] !== 8'hFF || q_dest[i] !== 2'd2) bad_d++;
        checks++; if (q_data.size() !== 2) begin errors++; $display("FAIL const_beats got %0d want 2", q_data.size()); end
        checks++; if (bad_d !== 0) begin errors++; $display("FAIL const_beat_fields got %0d bad want 0", bad_d); end
        checks++; if ({q_last[0], q_last[1]} !== 2'b01) begin errors++;
            $display("FAIL const_tlast got %b%b want 01", q_last[0], q_last[1]); end
        checks++; if (n_unstable !== 0) begin errors++; $display("FAIL const_stall_stable got %0d changes want 0", n_unstable); end
        checks++; if (n_finish !== 1) begin errors++; $display("FAIL const_finish got %0d want 1", n_finish); end
    endtask

    task automatic test_short();
        issue(32'h01000100, 64'h1234);
        collect(50, 0, -1, -1, -1);
        checks++; if (q_data.size() !== 1) begin errors++; $display("FAIL len1_beats got %0d want 1", q_data.size()); end
        checks++; if ({q_data[0], q_keep[0], q_last[0], q_dest[0]} !== {64'h1234, 8'h01, 1'b1, 2'd1}) begin errors++;
            $display("FAIL len1_beat got %h/%h/%b/%0d want 1234/01/1/1", q_data[0], q_keep[0], q_last[0], q_dest[0]); end
        issue(32'h00000800, 64'h77);
        collect(50, 0, -1, -1, -1);
        checks++; if (q_data.size() !== 1) begin errors++; $display("FAIL len8_beats got %0d want 1", q_data.size()); end
        checks++; if ({q_data[0], q_keep[0], q_last[0]} !== {64'h77, 8'hFF, 1'b1}) begin errors++;
            $display("FAIL len8_beat got %h/%h/%b want 77/ff/1", q_data[0], q_keep[0], q_last[0]); end
        checks++; if (n_finish !== 1) begin errors++; $display("FAIL len8_finish got %0d want 1", n_finish); end
    endtask

    task automatic test_errors();
        logic [31:0] cmds [3];
        int errs = 0, valids = 0;
        cmds[0] = 32'h05000800; cmds[1] = 32'h00000803; cmds[2] = 32'h00000000;
        for (int c = 0; c < 3; c++) begin
            issue(cmds[c], 64'h1);
            for (int k = 0; k < 4; k++) begin
                @(negedge sclk);
                if (k == 0) cmd_reg[2] = 1'b0;
                if (cmd_err) errs++;
                if (m_axis_tvalid || busy) valids++;
            end
        end
        checks++; if (errs !== 3) begin errors++; $display("FAIL err_pulses got %0d want 3", errs); end
        checks++; if (valids !== 0) begin errors++; $display("FAIL err_no_burst got %0d active cycles want 0", valids); end
    endtask

    task automatic test_abort();
        int bad = 0, act = 0;
        issue(32'h03032000, 64'h100);
        collect(1000, 0, 10, 5, -1);
        cmd_reg[3] = 1'b0;
        for (int i = 0; i < q_data.size(); i++)
            if (q_data[i] !== 64'(i + 'h100) || q_keep[i] !== 8'hFF || q_last[i] !== (i == 10) || q_dest[i] !== 2'd3) bad++;
        checks++; if (q_data.size() !== 11) begin errors++; $display("FAIL abort_beats got %0d want 11", q_data.size()); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL abort_beat_fields got %0d bad want 0", bad); end
        checks++; if (n_finish !== 1) begin errors++; $display("FAIL abort_finish got %0d want 1", n_finish); end
        checks++; if (n_err !== 0) begin errors++; $display("FAIL abort_restart_err got %0d want 0", n_err); end
        repeat (6) begin
            @(negedge sclk);
            if (m_axis_tvalid || cmd_err) act++;
        end
        checks++; if (act !== 0) begin errors++; $display("FAIL abort_no_queue got %0d active cycles want 0", act); end
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        issue(32'h00032000, 64'd0);
        collect(1000, 0, -1, -1, 50);
        checks++; if (rst_valid !== 1'b0) begin errors++; $display("FAIL rst_async_tvalid got %b want 0", rst_valid); end
        checks++; if (q_data.size() !== 50) begin errors++; $display("FAIL rst_beats got %0d want 50", q_data.size()); end
        checks++; if (n_finish !== 0) begin errors++; $display("FAIL rst_no_finish got %0d want 0", n_finish); end
        issue(32'h00001801, 64'hDEAD);
        collect(100, 0, -1, -1, -1);
        for (int i = 0; i < q_data.size(); i++) if (q_data[i] !== 64'hDEAD || q_keep[i] !== 8'hFF) bad++;
        checks++; if (q_data.size() !== 3) begin errors++; $display("FAIL rst_fresh_beats got %0d want 3", q_data.size()); end
        checks++; if (bad !== 0 || q_last[2] !== 1'b1) begin errors++;
            $display("FAIL rst_fresh_fields got %0d bad tlast %b want 0 1", bad, q_last[2]); end
        checks++; if (n_finish !== 1) begin errors++; $display("FAIL rst_fresh_finish got %0d want 1", n_finish); end
    endtask

    task automatic test_back_to_back();
        int act = 0;
        issue(32'h01001000, 64'd5);
        collect(100, 0, -1, -1, -1);
        // Start raised while the FSM sits in DONE must be dropped.
        cmd_reg  = 32'h00000804;
        cfg_seed = 64'd9;
        repeat (4) begin
            @(negedge sclk);
            if (m_axis_tvalid || cmd_err) act++;
        end
        checks++; if (act !== 0) begin errors++; $display("FAIL b2b_done_ignored got %0d active cycles want 0", act); end
        cmd_reg[2] = 1'b0;
        @(negedge sclk);
        cmd_reg[2] = 1'b1;
        collect(50, 0, -1, -1, -1);
        checks++; if (q_data.size() !== 1 || q_data[0] !== 64'd9) begin errors++;
            $display("FAIL b2b_second got %0d beats data %h want 1 beat 9", q_data.size(), q_data[0]); end
        // Next start one cycle after task_finish.
        @(negedge sclk);
        cmd_reg  = 32'h00000804;
        cfg_seed = 64'h42;
        collect(50, 0, -1, -1, -1);
        checks++; if (first_valid !== 2 || q_data.size() !== 1 || q_data[0] !== 64'h42) begin errors++;
            $display("FAIL b2b_min_gap got lat %0d beats %0d data %h want 2 1 42", first_valid, q_data.size(), q_data[0]); end
    endtask

    initial begin
        test_reset();
        test_long_inc();
        test_const_stall();
        test_short();
        test_errors();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_burst_gen.md
AXIS_BURST_GEN -- requirements
Module: axis_burst_gen

Interface
REQ-001 Parameter DATA_W, default 64, stream data width in bits; SHALL be a power of two and at least 8.
REQ-002 Parameter KEEP_W, default DATA_W/8, tkeep width in bytes.
REQ-003 Parameter CH_N, default 4, number of destination channels; CH_W = max(1, clog2(CH_N)).
REQ-004 sclk  in  1  single clock, all logic on its rising edge.
REQ-005 s_rst  in  1  asynchronous, active-high reset.
REQ-006 cmd_reg  in  32  command word: [1:0] mode, [2] start, [3] abort, [23:8] byte length, [27:24] channel.
REQ-007 cfg_seed  in  DATA_W  data seed, sampled at start.
REQ-008 m_axis_tdata  out  DATA_W  stream data.
REQ-009 m_axis_tkeep  out  KEEP_W  byte enables.
REQ-010 m_axis_tvalid  out  1  beat valid.
REQ-011 m_axis_tready  in  1  sink ready.
REQ-012 m_axis_tlast  out  1  final beat of burst.
REQ-013 m_axis_tdest  out  CH_W  latched channel.
REQ-014 busy  out  1  high in RUN and DONE.
REQ-015 task_finish  out  1  one-cycle completion pulse.
REQ-016 cmd_err  out  1  one-cycle rejected-command pulse.

Function
REQ-017 Start SHALL be the rising edge of cmd_reg[2], detected against a registered copy of the previous value; a level held high SHALL NOT retrigger.
REQ-018 FSM states SHALL be IDLE, RUN and DONE.
REQ-019 IDLE + start edge + valid command SHALL latch mode, length, channel and cfg_seed, then go to RUN on the next cycle.
REQ-020 A command SHALL be invalid if length = 0, channel >= CH_N, or mode is 2 or 3.
REQ-021 An invalid command SHALL pulse cmd_err for one cycle and remain in IDLE.
REQ-022 Beats SHALL equal ceil(length/KEEP_W).
REQ-023 Non-last beats SHALL carry tkeep all ones.
REQ-024 The last beat SHALL carry tkeep with the low (length mod KEEP_W) bits set, or all ones when the remainder is 0.
REQ-025 In RUN, tvalid SHALL be 1.
REQ-026 A beat SHALL be transferred only when tvalid and tready are both high.
REQ-027 tdata, tkeep, tlast and tdest SHALL hold stable while tvalid is high and tready is low.
REQ-028 Mode 0 SHALL output tdata = seed + beat index, modulo 2^DATA_W, with index starting at 0.
REQ-029 Mode 1 SHALL output tdata = seed on every beat.
REQ-030 When the last beat is transferred, the FSM SHALL go to DONE; DONE SHALL assert task_finish for one cycle and then return to IDLE.
REQ-031 If abort (cmd_reg[3]) is high in RUN, the next beat presented SHALL be marked tlast with tkeep all ones; tvalid SHALL NOT drop without a handshake.
REQ-032 An abort arriving while a beat is stalled SHALL take effect on the following beat.
REQ-033 A start edge in RUN or DONE SHALL be ignored, with no cmd_err and no queuing.
REQ-034 A 1-beat burst SHALL present tlast on its first beat.
REQ-035 Back-to-back operation SHALL be possible: start edge to first tvalid is 2 cycles; task_finish to next accepted start is 1 cycle minimum.

Reset
REQ-036 s_rst high SHALL asynchronously force IDLE.
REQ-037 Reset SHALL clear tvalid, tlast, tdata, tkeep, tdest, busy, task_finish, cmd_err, the beat counter and the start-edge register to 0.
REQ-038 Reset asserted mid-burst SHALL drop tvalid immediately; no task_finish SHALL follow.

Structure
REQ-039 Shared package accel_pkg SHALL hold the FSM state enum, the cmd_reg field positions and the mode codes.
REQ-040 Sub-module axis_cmd_decode SHALL handle edge detection, validity checking, beat count and last-tkeep computation; the top SHALL hold the FSM and the datapath.

Verification
REQ-041 Scenario: cmd_reg 0x0066D780 then 0x0066D784, mode 0, seed 0, tready = 1 -> 3291 beats; tdata 0..3290; last tkeep 0x7F; one task_finish.
REQ-042 Scenario: length 16, mode 1, seed 0xA5A5..., tready toggling every cycle -> 2 beats, both 0xA5A5..., stable during stalls, tlast on beat 2, tkeep 0xFF.
REQ-043 Scenario: length 1 and length 8 -> 1 beat each with tlast; tkeep 0x01 and 0xFF respectively.
REQ-044 Scenario: channel 5 with CH_N = 4, then mode 3, then length 0 -> cmd_err pulses three times; tvalid stays 0.
REQ-045 Scenario: length 800 (100 beats), abort raised after beat 10 -> beat 11 carries tlast with tkeep 0xFF; task_finish follows; a start edge during the burst is ignored.
REQ-046 Scenario: s_rst pulsed at beat 50 -> tvalid drops asynchronously; no task_finish; a fresh start afterwards runs normally.
